glitch_sweeper: RTL and testbench



---
 rtl/glitch_pkg.sv | 27 ++
 rtl/glitch_sweeper_if.sv | 32 +++
 rtl/sync_edge.sv | 16 +
 rtl/glitch_sweeper.sv | 174 +++++++++++++++++
 tb/tb_glitch_sweeper.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/glitch_pkg.sv
// Shared types and constants for the supply-rail glitch sweeper.
package glitch_pkg;

  typedef enum logic [2:0] {
    IDLE, RESET, SETTLE, ARM, DELAY, GLITCH, GAP, DONE
  } state_t;

  localparam logic [3:0] LED_OFF   = 4'b0000;
  localparam logic [3:0] LED_RESET = 4'b0001;
  localparam logic [3:0] LED_PREP  = 4'b0010;
  localparam logic [3:0] LED_FIRE  = 4'b0100;
  localparam logic [3:0] LED_DONE  = 4'b1000;

  localparam logic MODE_FREE = 1'b0;
  localparam logic MODE_TRIG = 1'b1;

  function automatic logic [3:0] led_of(input state_t s);
    case (s)
      RESET:              led_of = LED_RESET;
      SETTLE, ARM:        led_of = LED_PREP;
      DELAY, GLITCH, GAP: led_of = LED_FIRE;
      DONE:               led_of = LED_DONE;
      default:            led_of = LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/glitch_sweeper_if.sv
// Control/status bundle between the sweeper and its host (LED/UART/test logic).
interface glitch_sweeper_if
  import glitch_pkg::*;
#(
  parameter int DLY_W = 16,
  parameter int WID_W = 8
) ();
  // start: one-cycle request, honoured only in IDLE or DONE; abort: level, wins over everything.
  logic             start;
  logic             abort;
  logic             mode;
  logic             trig;
  logic             target_pwr;
  logic             busy;
  logic             done;
  logic             glitch_stb;
  logic [DLY_W-1:0] cur_delay;
  logic [WID_W-1:0] cur_width;
  logic [31:0]      attempt;
  logic [3:0]       state_led;
  state_t           state;

  modport master (
    output start, abort, mode, trig,
    input  target_pwr, busy, done, glitch_stb, cur_delay, cur_width, attempt, state_led, state
  );

  modport slave (
    input  start, abort, mode, trig,
    output target_pwr, busy, done, glitch_stb, cur_delay, cur_width, attempt, state_led, state
  );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse, for the asynchronous target trigger.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], din};
  end

  assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/glitch_sweeper.sv
// Supply-drop glitch sweeper: power-cycle, settle, then sweep delay x width glitches.
// Optional GLITCH_TRIG_TIMEOUT_EN: in triggered mode, ARM gives up after TMO_LEN cycles.
module glitch_sweeper
  import glitch_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int RESET_LEN  = CLK_HZ,
  parameter int SETTLE_LEN = CLK_HZ / 2000,
  parameter int GAP_LEN    = CLK_HZ / 2000,
  parameter int REPS       = 5000,
  parameter int DLY_W      = 16,
  parameter int WID_W      = 8,
  parameter int DELAY_MIN  = 0,
  parameter int DELAY_MAX  = 100,
  parameter int DELAY_STEP = 1,
  parameter int WIDTH_MIN  = 1,
  parameter int WIDTH_MAX  = 4,
  parameter int TMO_LEN    = CLK_HZ
) (
  input logic              clk,
  input logic              rst_n,
  glitch_sweeper_if.slave  bus
);

  if (CLK_HZ < 1 || RESET_LEN < 1 || SETTLE_LEN < 1 || GAP_LEN < 1 || REPS < 1 ||
      DELAY_STEP < 1 || WIDTH_MIN < 1 || WIDTH_MAX < WIDTH_MIN || TMO_LEN < 1) begin : g_param_err
    $error("glitch_sweeper: illegal parameter set");
  end

`ifdef GLITCH_TRIG_TIMEOUT_EN
  localparam logic [31:0] ARM_LOAD = 32'(TMO_LEN - 1);
`else
  localparam logic [31:0] ARM_LOAD = '0;
`endif

  state_t           state, state_n;
  logic [31:0]      cnt, cnt_n;
  logic [31:0]      rep, rep_n;
  logic [DLY_W-1:0] delay_q, delay_n;
  logic [WID_W-1:0] width_q, width_n;
  logic [31:0]      attempt_q, attempt_n;
  logic             mode_q, mode_n;
  logic [DLY_W:0]   delay_next;
  logic             trig_rise, fire;
  logic             pwr_q, busy_q, done_q, stb_q;
  logic [3:0]       led_q;

  sync_edge u_trig_sync (.clk(clk), .rst_n(rst_n), .din(bus.trig), .rise(trig_rise));

  assign fire       = (mode_q == MODE_FREE) || (mode_q == MODE_TRIG && trig_rise);
  assign delay_next = {1'b0, delay_q} + (DLY_W+1)'(DELAY_STEP);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rep_n     = rep;
    delay_n   = delay_q;
    width_n   = width_q;
    attempt_n = attempt_q;
    mode_n    = mode_q;
    if (bus.abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          mode_n    = bus.mode;
          delay_n   = DLY_W'(DELAY_MIN);
          width_n   = WID_W'(WIDTH_MIN);
          attempt_n = '0;
          rep_n     = '0;
          state_n   = RESET;
          cnt_n     = 32'(RESET_LEN - 1);
        end
        RESET: if (cnt == '0) begin
          state_n = SETTLE;
          cnt_n   = 32'(SETTLE_LEN - 1);
        end else cnt_n = cnt - 32'd1;
        SETTLE: if (cnt == '0) begin
          state_n = ARM;
          cnt_n   = ARM_LOAD;
        end else cnt_n = cnt - 32'd1;
        ARM: begin
          if (fire && delay_q == '0) begin
            state_n   = GLITCH;
            cnt_n     = 32'(width_q) - 32'd1;
            attempt_n = attempt_q + 32'd1;
          end else if (fire) begin
            state_n = DELAY;
            cnt_n   = 32'(delay_q) - 32'd1;
          end
`ifdef GLITCH_TRIG_TIMEOUT_EN
          // Retry the same grid point from a fresh power cycle; rep is kept.
          else if (cnt == '0) begin
            state_n = RESET;
            cnt_n   = 32'(RESET_LEN - 1);
          end else cnt_n = cnt - 32'd1;
`endif
        end
        DELAY: if (cnt == '0) begin
          state_n   = GLITCH;
          cnt_n     = 32'(width_q) - 32'd1;
          attempt_n = attempt_q + 32'd1;
        end else cnt_n = cnt - 32'd1;
        GLITCH: if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = 32'(GAP_LEN - 1);
        end else cnt_n = cnt - 32'd1;
        GAP: if (cnt != '0) begin
          cnt_n = cnt - 32'd1;
        end else if (rep < 32'(REPS - 1)) begin
          rep_n   = rep + 32'd1;
          state_n = ARM;
          cnt_n   = ARM_LOAD;
        end else if (width_q < WID_W'(WIDTH_MAX)) begin
          width_n = width_q + WID_W'(1);
          rep_n   = '0;
          state_n = RESET;
          cnt_n   = 32'(RESET_LEN - 1);
        end else if (delay_next > (DLY_W+1)'(DELAY_MAX)) begin
          state_n = DONE;
        end else begin
          delay_n = delay_next[DLY_W-1:0];
          width_n = WID_W'(WIDTH_MIN);
          rep_n   = '0;
          state_n = RESET;
          cnt_n   = 32'(RESET_LEN - 1);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Status flops are loaded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rep       <= '0;
      delay_q   <= DLY_W'(DELAY_MIN);
      width_q   <= WID_W'(WIDTH_MIN);
      attempt_q <= '0;
      mode_q    <= MODE_FREE;
      pwr_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stb_q     <= 1'b0;
      led_q     <= LED_OFF;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rep       <= rep_n;
      delay_q   <= delay_n;
      width_q   <= width_n;
      attempt_q <= attempt_n;
      mode_q    <= mode_n;
      pwr_q     <= state_n inside {SETTLE, ARM, DELAY, GAP, DONE};
      busy_q    <= !(state_n inside {IDLE, DONE});
      done_q    <= (state_n == DONE);
      stb_q     <= (state_n == GLITCH) && (state != GLITCH);
      led_q     <= led_of(state_n);
    end
  end

  assign bus.target_pwr = pwr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.glitch_stb = stb_q;
  assign bus.cur_delay  = delay_q;
  assign bus.cur_width  = width_q;
  assign bus.attempt    = attempt_q;
  assign bus.state_led  = led_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_glitch_sweeper.sv
// Directed bench for glitch_sweeper with a small grid (delay 0..2, width 1..2, 2 reps).
module tb_glitch_sweeper;
  import glitch_pkg::*;

  localparam int DLY_W = 16;
  localparam int WID_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  glitch_sweeper_if #(.DLY_W(DLY_W), .WID_W(WID_W)) bus ();

  glitch_sweeper #(
    .CLK_HZ(1000), .RESET_LEN(4), .SETTLE_LEN(3), .GAP_LEN(2), .REPS(2),
    .DLY_W(DLY_W), .WID_W(WID_W), .DELAY_MIN(0), .DELAY_MAX(2), .DELAY_STEP(1),
    .WIDTH_MIN(1), .WIDTH_MAX(2), .TMO_LEN(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  // Returns at the first sample after the clock edge that accepts START.
  task automatic pulse_start(input logic m);
    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, "_pwr"},     32'(bus.target_pwr), 32'd0);
    check({pfx, "_busy"},    32'(bus.busy),       32'd0);
    check({pfx, "_done"},    32'(bus.done),       32'd0);
    check({pfx, "_stb"},     32'(bus.glitch_stb), 32'd0);
    check({pfx, "_delay"},   32'(bus.cur_delay),  32'd0);
    check({pfx, "_width"},   32'(bus.cur_width),  32'd1);
    check({pfx, "_attempt"}, bus.attempt,         32'd0);
    check({pfx, "_led"},     32'(bus.state_led),  32'(LED_OFF));
    check({pfx, "_state"},   32'(bus.state),      32'(IDLE));
  endtask

  logic pwr_tr [128];
  logic stb_tr [128];

  initial begin
    int n, busy_cnt, stb_cnt, rst_cnt;
    logic prev_led0;
    logic [6:0] v;

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode  = MODE_FREE;
    bus.trig  = 1'b0;
    for (int i = 0; i < 128; i++) begin
      pwr_tr[i] = 1'b0;
      stb_tr[i] = 1'b0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_idle("por");

    // Full free-running sweep: 6 points x 2 reps, 108 busy cycles in total.
    pulse_start(MODE_FREE);
    n = 0; busy_cnt = 0; stb_cnt = 0; rst_cnt = 0; prev_led0 = 1'b0;
    while (!bus.done && n < 200) begin
      if (n < 128) begin
        pwr_tr[n] = bus.target_pwr;
        stb_tr[n] = bus.glitch_stb;
      end
      if (bus.busy) busy_cnt++;
      if (bus.glitch_stb) stb_cnt++;
      if (bus.state_led[0] && !prev_led0) rst_cnt++;
      prev_led0 = bus.state_led[0];
      n++;
      tick();
    end
    check("sweep_len",      32'(n),        32'd108);
    check("sweep_busy",     32'(busy_cnt), 32'd108);
    check("sweep_glitches", 32'(stb_cnt),  32'd12);
    check("sweep_resets",   32'(rst_cnt),  32'd6);
    check("done_flag",      32'(bus.done),       32'd1);
    check("done_busy",      32'(bus.busy),       32'd0);
    check("done_pwr",       32'(bus.target_pwr), 32'd1);
    check("done_attempt",   bus.attempt,         32'd12);
    check("done_delay",     32'(bus.cur_delay),  32'd2);
    check("done_width",     32'(bus.cur_width),  32'd2);
    check("done_led",       32'(bus.state_led),  32'(LED_DONE));
    for (int i = 0; i < 7; i++) v[i] = pwr_tr[i];
    check("pwrup_trace", 32'(v), 32'(7'b1110000));
    // Last rep of point (2,2): ARM 101, DELAY 102-103, GLITCH 104-105, GAP 106-107.
    for (int i = 0; i < 7; i++) v[i] = pwr_tr[101 + i];
    check("last_pt_pwr", 32'(v), 32'(7'b1100111));
    for (int i = 0; i < 7; i++) v[i] = stb_tr[101 + i];
    check("last_pt_stb", 32'(v), 32'(7'b0001000));

    // Restart from DONE, then abort during the first GLITCH (sample 8).
    pulse_start(MODE_FREE);
    check("restart_attempt", bus.attempt,      32'd0);
    check("restart_busy",    32'(bus.busy),    32'd1);
    repeat (8) tick();
    check("abort_pre_stb",   32'(bus.glitch_stb), 32'd1);
    check("abort_pre_state", 32'(bus.state),      32'(GLITCH));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_state",   32'(bus.state),      32'(IDLE));
    check("abort_pwr",     32'(bus.target_pwr), 32'd0);
    check("abort_busy",    32'(bus.busy),       32'd0);
    check("abort_attempt", bus.attempt,         32'd1);
    pulse_start(MODE_FREE);
    check("abort_restart_attempt", bus.attempt, 32'd0);

    // Asynchronous reset in the first GAP (sample 9).
    repeat (9) tick();
    check("gap_led", 32'(bus.state_led),  32'(LED_FIRE));
    check("gap_pwr", 32'(bus.target_pwr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pwr",  32'(bus.target_pwr), 32'd0);
    check("arst_busy", 32'(bus.busy),       32'd0);
    check("arst_stb",  32'(bus.glitch_stb), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_idle("post_rst");

`ifndef GLITCH_TRIG_TIMEOUT_EN
    // Triggered mode: ARM from sample 7, pin edge after sample 17, GLITCH at sample 20.
    pulse_start(MODE_TRIG);
    repeat (7) tick();
    for (int i = 7; i < 17; i++) exp_q.push_back(32'({LED_PREP, 1'b1}));
    while (exp_q.size() > 0) begin
      check("arm_wait", 32'({bus.state_led, bus.target_pwr}), exp_q.pop_front());
      tick();
    end
    bus.trig = 1'b1;
    tick();
    bus.trig = 1'b0;
    check("trig_s1_stb", 32'(bus.glitch_stb), 32'd0);
    check("trig_s1_pwr", 32'(bus.target_pwr), 32'd1);
    tick();
    check("trig_s2_stb", 32'(bus.glitch_stb), 32'd0);
    tick();
    check("trig_glitch_stb",     32'(bus.glitch_stb), 32'd1);
    check("trig_glitch_pwr",     32'(bus.target_pwr), 32'd0);
    check("trig_glitch_attempt", bus.attempt,         32'd1);
    repeat (23) tick();
    check("notrig_state", 32'(bus.state),      32'(ARM));
    check("notrig_pwr",   32'(bus.target_pwr), 32'd1);
    check("notrig_attempt", bus.attempt,       32'd1);
`else
    // Timeout: ARM samples 7..11, RESET re-entered at sample 12, same grid point.
    pulse_start(MODE_TRIG);
    repeat (7) tick();
    for (int i = 0; i < 5; i++) begin
      check("tmo_arm", 32'(bus.state_led), 32'(LED_PREP));
      tick();
    end
    check("tmo_led",     32'(bus.state_led),  32'(LED_RESET));
    check("tmo_pwr",     32'(bus.target_pwr), 32'd0);
    check("tmo_delay",   32'(bus.cur_delay),  32'd0);
    check("tmo_width",   32'(bus.cur_width),  32'd1);
    check("tmo_attempt", bus.attempt,         32'd0);
    repeat (7) tick();
    check("tmo_rearm", 32'(bus.state), 32'(ARM));
`endif
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("final_state", 32'(bus.state), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
